// File: rtl/subtrator_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package subtrator_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/subtrator_serial_cell.sv
// One-bit full subtractor: diff = a - b - borrow_in, borrow_out set when the bit underflows.
module subtratorcompleto_behav (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    always_comb begin
        diff       = a ^ b ^ borrow_in;
        borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
    end

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial WIDTH-bit subtractor (a - b - borrow_in), LSB first through one cell.
// Optional signed-overflow output enabled by defining SUBTRATOR_SERIAL_OVF_EN.
module subtrator_serial
    import subtrator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SUBTRATOR_SERIAL_OVF_EN
    output logic             overflow,
`endif
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] aSh_q;
    logic [WIDTH-1:0] bSh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             brw_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrowOut_q;
    logic             cellDiff;
    logic             cellBorrow;

`ifdef SUBTRATOR_SERIAL_OVF_EN
    logic aMsb_q;
    logic bMsb_q;
    logic ovf_q;
    assign overflow = ovf_q;
`endif

    subtratorcompleto_behav u_cell (
        .a          (aSh_q[0]),
        .b          (bSh_q[0]),
        .borrow_in  (brw_q),
        .diff       (cellDiff),
        .borrow_out (cellBorrow)
    );

    // Result assembles from the top so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_d = {cellDiff, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aSh_q       <= '0;
            bSh_q       <= '0;
            res_q       <= '0;
            brw_q       <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            diff_q      <= '0;
            borrowOut_q <= 1'b0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
            aMsb_q      <= 1'b0;
            bMsb_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        aSh_q   <= a;
                        bSh_q   <= b;
                        brw_q   <= borrow_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef SUBTRATOR_SERIAL_OVF_EN
                        aMsb_q  <= a[WIDTH-1];
                        bMsb_q  <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    brw_q <= cellBorrow;
                    res_q <= res_d;
                    aSh_q <= {1'b0, aSh_q[WIDTH-1:1]};
                    bSh_q <= {1'b0, bSh_q[WIDTH-1:1]};
                    if (cnt_q == LAST_BIT) begin
                        cnt_q       <= '0;
                        diff_q      <= res_d;
                        borrowOut_q <= cellBorrow;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
`ifdef SUBTRATOR_SERIAL_OVF_EN
                        ovf_q       <= (aMsb_q != bMsb_q) && (res_d[WIDTH-1] != aMsb_q);
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrowOut_q;

endmodule
